// File: rtl/netlist_rx_deframer.sv
// Serial frame deframer: hunts for a sync word, locks to frame boundaries,
// deserialises MSB-first data words and buffers them in a show-ahead FIFO.
module netlist_rx_deframer #(
  parameter int unsigned             SYNC_WIDTH   = 8,
  parameter logic [SYNC_WIDTH-1:0]   SYNC_PATTERN = 8'hA5,
  parameter int unsigned             DATA_WIDTH   = 8,
  parameter int unsigned             FRAME_WORDS  = 4,
  parameter int unsigned             FIFO_DEPTH   = 4,
  parameter int unsigned             MISS_MAX     = 2
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  SIN,
  input  logic                  BIT_EN,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DVALID,
  input  logic                  DREADY,
  output logic                  LOCKED,
  output logic                  OVERFLOW
);

  localparam int unsigned SREG_W = (SYNC_WIDTH > DATA_WIDTH) ? SYNC_WIDTH : DATA_WIDTH;
  // The newest bit comes straight from SIN, so only SREG_W-1 history bits are stored.
  localparam int unsigned HIST_W = SREG_W - 1;
  localparam int unsigned CNT_W  = $clog2(SREG_W);
  localparam int unsigned WCNT_W = $clog2(FRAME_WORDS + 1);
  localparam int unsigned MCNT_W = $clog2(MISS_MAX + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0]  DataLast  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  SyncLast  = CNT_W'(SYNC_WIDTH - 1);
  localparam logic [WCNT_W-1:0] WordLast  = WCNT_W'(FRAME_WORDS - 1);
  localparam logic [MCNT_W-1:0] MissLimit = MCNT_W'(MISS_MAX);
  localparam logic [OCC_W-1:0]  OccFull   = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StHunt, StData, StCheck} state_e;

  state_e                  state;
  logic [HIST_W-1:0]       hist;
  logic [CNT_W-1:0]        bit_cnt;
  logic [WCNT_W-1:0]       word_cnt;
  logic [MCNT_W-1:0]       miss_cnt;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [OCC_W-1:0]        occ;
  logic                    ovf;

  logic [SYNC_WIDTH-1:0]   sync_word;
  logic [DATA_WIDTH-1:0]   data_word;
  logic                    sync_match;
  logic [MCNT_W-1:0]       miss_inc;
  logic                    push_req;
  logic                    pop;
  logic                    full;
  logic                    push_ok;

  // Incoming words include the bit on SIN this cycle; decode push/pop conditions.
  always_comb begin
    sync_word  = {hist[SYNC_WIDTH-2:0], SIN};
    data_word  = {hist[DATA_WIDTH-2:0], SIN};
    sync_match = (sync_word == SYNC_PATTERN);
    miss_inc   = miss_cnt + MCNT_W'(1);
    push_req   = (state == StData) && BIT_EN && (bit_cnt == DataLast);
    pop        = DVALID && DREADY;
    full       = (occ == OccFull);
    // A pop on the same edge frees the slot the push needs.
    push_ok    = push_req && (!full || pop);
  end

  // Frame FSM: hunt for sync, count data bits/words, then verify trailing sync.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= StHunt;
      hist     <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      miss_cnt <= '0;
    end else if (BIT_EN) begin
      hist <= {hist[HIST_W-2:0], SIN};
      case (state)
        StHunt: begin
          if (sync_match) begin
            state    <= StData;
            bit_cnt  <= '0;
            word_cnt <= '0;
            miss_cnt <= '0;
          end
        end
        StData: begin
          if (bit_cnt == DataLast) begin
            bit_cnt <= '0;
            if (word_cnt == WordLast) begin
              word_cnt <= '0;
              state    <= StCheck;
            end else begin
              word_cnt <= word_cnt + WCNT_W'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        StCheck: begin
          if (bit_cnt == SyncLast) begin
            bit_cnt <= '0;
            if (sync_match) begin
              miss_cnt <= '0;
              state    <= StData;
            end else if (miss_inc == MissLimit) begin
              miss_cnt <= '0;
              state    <= StHunt;
            end else begin
              // Flywheel: keep the assumed alignment through an isolated miss.
              miss_cnt <= miss_inc;
              state    <= StData;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= StHunt;
      endcase
    end
  end

  // FIFO control: pointers, occupancy and sticky overflow.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (push_req && !push_ok) ovf <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while unoccupied.
  always_ff @(posedge CLOCK) begin
    if (push_ok) mem[wr_ptr] <= data_word;
  end

  // Outputs are derived from registered state only.
  always_comb begin
    DVALID   = (occ != '0);
    DOUT     = DVALID ? mem[rd_ptr] : '0;
    LOCKED   = (state != StHunt);
    OVERFLOW = ovf;
  end

endmodule

// File: tb/tb_netlist_rx_deframer.sv
// Directed bench for netlist_rx_deframer: lock, flywheel, backpressure,
// full-with-pop, BIT_EN gaps and mid-frame reset.
module tb_netlist_rx_deframer;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       SIN;
  logic       BIT_EN;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       DREADY;
  logic       LOCKED;
  logic       OVERFLOW;

  int n_vec = 0;
  int n_err = 0;
  logic gap = 1'b0;

  logic [7:0] frame_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] frame_b [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] drain_x [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

  netlist_rx_deframer dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .SIN      (SIN),
    .BIT_EN   (BIT_EN),
    .DOUT     (DOUT),
    .DVALID   (DVALID),
    .DREADY   (DREADY),
    .LOCKED   (LOCKED),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    RESET  = 1'b1;
    BIT_EN = 1'b0;
    SIN    = 1'b0;
    DREADY = 1'b0;
    tick();
    tick();
    RESET  = 1'b0;
  endtask

  // With gap set, a BIT_EN=0 cycle carrying the inverted bit precedes each real bit.
  task automatic send_bit(input logic b);
    if (gap) begin
      BIT_EN = 1'b0;
      SIN    = ~b;
      tick();
    end
    BIT_EN = 1'b1;
    SIN    = b;
    tick();
    BIT_EN = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[7-i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  // Lock-and-receive sequence with DREADY high; each word appears right after its last bit.
  task automatic run_basic(input string tag);
    reset_dut();
    DREADY = 1'b1;
    send_byte(8'h3C);
    chk({tag, "_noise_unlocked"}, 32'(LOCKED), 32'd0);
    send_bits(8'hA5, 7);
    chk({tag, "_lock_early"}, 32'(LOCKED), 32'd0);
    send_bit(1'b1);
    chk({tag, "_lock_rise"}, 32'(LOCKED), 32'd1);
    chk({tag, "_empty_after_sync"}, 32'(DVALID), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_byte(frame_a[i]);
      chk({tag, "_word_valid"}, 32'(DVALID), 32'd1);
      chk({tag, "_word_data"}, 32'(DOUT), 32'(frame_a[i]));
    end
    send_byte(8'hA5);
    chk({tag, "_drained"}, 32'(DVALID), 32'd0);
    chk({tag, "_stay_locked"}, 32'(LOCKED), 32'd1);
    chk({tag, "_no_ovf"}, 32'(OVERFLOW), 32'd0);
  endtask

  initial begin
    RESET  = 1'b1;
    SIN    = 1'b0;
    BIT_EN = 1'b0;
    DREADY = 1'b0;
    reset_dut();
    chk("rst_dvalid", 32'(DVALID), 32'd0);
    chk("rst_locked", 32'(LOCKED), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);

    // Lock and receive, continuous BIT_EN.
    gap = 1'b0;
    run_basic("basic");

    // Flywheel through one missed sync, lose lock on the second.
    reset_dut();
    DREADY = 1'b1;
    send_byte(8'hA5);
    chk("fly_lock", 32'(LOCKED), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(frame_a[i]);
      chk("fly_f1_data", 32'(DOUT), 32'(frame_a[i]));
    end
    send_byte(8'h00);
    chk("fly_miss1_locked", 32'(LOCKED), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(frame_b[i]);
      chk("fly_f2_valid", 32'(DVALID), 32'd1);
      chk("fly_f2_data", 32'(DOUT), 32'(frame_b[i]));
    end
    send_bits(8'h00, 7);
    chk("fly_miss2_early", 32'(LOCKED), 32'd1);
    send_bit(1'b0);
    chk("fly_miss2_unlock", 32'(LOCKED), 32'd0);
    send_byte(8'h55);
    chk("fly_hunt_no_push", 32'(DVALID), 32'd0);

    // Backpressure: eight words into a four-entry FIFO.
    reset_dut();
    DREADY = 1'b0;
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(frame_a[i]);
    chk("bp_full_no_ovf", 32'(OVERFLOW), 32'd0);
    chk("bp_head", 32'(DOUT), 32'h11);
    send_byte(8'hA5);
    send_bits(8'h55, 7);
    chk("bp_ovf_early", 32'(OVERFLOW), 32'd0);
    send_bit(1'b1);
    chk("bp_ovf_set", 32'(OVERFLOW), 32'd1);
    for (int i = 1; i < 4; i++) send_byte(frame_b[i]);
    chk("bp_head_hold", 32'(DOUT), 32'h11);
    chk("bp_valid_hold", 32'(DVALID), 32'd1);
    DREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", 32'(DVALID), 32'd1);
      chk("bp_drain_data", 32'(DOUT), 32'(frame_a[i]));
      tick();
    end
    chk("bp_drain_empty", 32'(DVALID), 32'd0);
    chk("bp_ovf_sticky", 32'(OVERFLOW), 32'd1);

    // Full FIFO, pop on the same edge the next word completes.
    reset_dut();
    DREADY = 1'b0;
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(frame_a[i]);
    send_byte(8'hA5);
    send_bits(8'h55, 7);
    DREADY = 1'b1;
    send_bit(1'b1);
    DREADY = 1'b0;
    chk("fp_no_ovf", 32'(OVERFLOW), 32'd0);
    chk("fp_valid", 32'(DVALID), 32'd1);
    chk("fp_head", 32'(DOUT), 32'h22);
    DREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fp_drain_data", 32'(DOUT), 32'(drain_x[i]));
      tick();
    end
    chk("fp_drain_empty", 32'(DVALID), 32'd0);

    // Same as basic with BIT_EN low every other cycle.
    gap = 1'b1;
    run_basic("gap");
    gap = 1'b0;

    // Reset mid-frame with two words buffered, then relock.
    reset_dut();
    DREADY = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("mr_two_held", 32'(DVALID), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mr_dvalid", 32'(DVALID), 32'd0);
    chk("mr_locked", 32'(LOCKED), 32'd0);
    chk("mr_ovf", 32'(OVERFLOW), 32'd0);
    chk("mr_dout", 32'(DOUT), 32'd0);
    send_byte(8'hA5);
    chk("mr_relock", 32'(LOCKED), 32'd1);
    DREADY = 1'b1;
    send_byte(8'h33);
    chk("mr_new_valid", 32'(DVALID), 32'd1);
    chk("mr_new_data", 32'(DOUT), 32'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
